// File: rtl/rw_seq_pkg.sv
// Shared types and widths for the write-then-read burst sequencer.
//   rw_state_e : sequencer phase encoding
//   CNT_W      : beat counter width
//   GAP_W      : turnaround counter width
package rw_seq_pkg;

  localparam int unsigned CNT_W = 8;
  localparam int unsigned GAP_W = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    TURN  = 3'd2,
    READ  = 3'd3,
    FLUSH = 3'd4
  } rw_state_e;

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for a level input.
//   clk, rst : clock and synchronous active-high reset
//   d        : level input
//   q_rose   : high in the cycle where d is 1 and was 0 on the previous edge
// The history register resets to 1 so a level already high through reset
// is not reported as a rising edge.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q_rose
);

  logic d_q;

  // Previous-cycle copy of d
  always_ff @(posedge clk) begin
    if (rst) begin
      d_q <= 1'b1;
    end else begin
      d_q <= d;
    end
  end

  assign q_rose = d & ~d_q;

endmodule

// File: rtl/rw_burst_sequencer.sv
// Sequences one write burst followed by one read burst on a single-port
// memory interface for every rising edge of start.
//   clk, rst     : clock, synchronous active-high reset
//   start        : request level; a transaction starts on its 0->1 edge
//   base_addr    : first address of both bursts (sampled on the start edge)
//   wr_data      : data for every write beat (sampled on the start edge)
//   mem_ready    : memory accepts the current beat when high
//   mem_rdata    : memory read data, captured when a read beat is accepted
//   wr, rd       : memory strobes (never high together)
//   addr, wdata  : beat address and write data
//   rdata_valid  : one-cycle pulse, rdata holds a newly returned word
//   rdata        : last captured read word
//   busy         : transaction in progress
//   done         : one-cycle pulse with the final rdata_valid
//   err          : one-cycle pulse when start rises while busy
module rw_burst_sequencer
  import rw_seq_pkg::*;
#(
  parameter int unsigned AW     = 8,
  parameter int unsigned DW     = 8,
  parameter int unsigned WR_LEN = 1,
  parameter int unsigned RD_LEN = 2,
  parameter int unsigned GAP    = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          mem_ready,
  input  logic [DW-1:0] mem_rdata,
  output logic          wr,
  output logic          rd,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] wdata,
  output logic          rdata_valid,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam logic [CNT_W-1:0] WR_LAST  = CNT_W'(WR_LEN - 1);
  localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(RD_LEN - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = (GAP == 0) ? '0 : GAP_W'(GAP - 1);

  rw_state_e        state_q,  state_d;
  logic [AW-1:0]    addr_q,   addr_d;
  logic [AW-1:0]    base_q,   base_d;
  logic [DW-1:0]    wdata_q,  wdata_d;
  logic [DW-1:0]    rdata_q,  rdata_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [GAP_W-1:0] gap_q,    gap_d;
  logic             wr_q,     wr_d;
  logic             rd_q,     rd_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;
  logic             err_q,    err_d;
  logic             rvalid_q, rvalid_d;
  logic             rose;

  rise_detect u_rise (
    .clk    (clk),
    .rst    (rst),
    .d      (start),
    .q_rose (rose)
  );

  // Next-state and next-output logic
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    base_d   = base_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    cnt_d    = cnt_q;
    gap_d    = gap_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    rvalid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (rose) begin
          state_d = WRITE;
          wr_d    = 1'b1;
          busy_d  = 1'b1;
          addr_d  = base_addr;
          base_d  = base_addr;
          wdata_d = wr_data;
          cnt_d   = '0;
        end
      end

      WRITE: begin
        if (wr_q && mem_ready) begin
          if (cnt_q == WR_LAST) begin
            // Read burst restarts from the original base address
            wr_d   = 1'b0;
            addr_d = base_q;
            cnt_d  = '0;
            gap_d  = '0;
            if (GAP == 0) begin
              state_d = READ;
              rd_d    = 1'b1;
            end else begin
              state_d = TURN;
            end
          end else begin
            addr_d = addr_q + AW'(1);
            cnt_d  = cnt_q + CNT_W'(1);
          end
        end
      end

      TURN: begin
        if (gap_q == GAP_LAST) begin
          state_d = READ;
          rd_d    = 1'b1;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end

      READ: begin
        if (rd_q && mem_ready) begin
          rvalid_d = 1'b1;
          rdata_d  = mem_rdata;
          addr_d   = addr_q + AW'(1);
          if (cnt_q == RD_LAST) begin
            // done lines up with the last rdata_valid
            rd_d    = 1'b0;
            done_d  = 1'b1;
            state_d = FLUSH;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      FLUSH: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
        wr_d    = 1'b0;
        rd_d    = 1'b0;
        busy_d  = 1'b0;
      end
    endcase

    // A request while a transaction (including its done cycle) is live is dropped
    if (rose && (state_q != IDLE)) begin
      err_d = 1'b1;
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      base_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      cnt_q    <= '0;
      gap_q    <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      base_q   <= base_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      cnt_q    <= cnt_d;
      gap_q    <= gap_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign wr          = wr_q;
  assign rd          = rd_q;
  assign addr        = addr_q;
  assign wdata       = wdata_q;
  assign rdata       = rdata_q;
  assign rdata_valid = rvalid_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_rw_burst_sequencer.sv
// Bench for rw_burst_sequencer: two instances (default parameters, and
// WR_LEN=3/GAP=2) share stimulus; a slot-queue model predicts every cycle.
module tb_rw_burst_sequencer;

  localparam int K_W = 0;  // write beat slot
  localparam int K_I = 1;  // turnaround slot
  localparam int K_R = 2;  // read beat slot
  localparam int K_F = 3;  // done/flush slot

  typedef struct {
    int         kind;
    logic [7:0] a;
  } slot_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       mem_ready = 1'b1;
  logic [7:0] base_addr = 8'h00;
  logic [7:0] wr_data = 8'h00;

  logic [7:0] mem_rdata [2];
  logic [1:0] wr, rd, rvalid, busy, done, err;
  logic [7:0] addr [2];
  logic [7:0] wdata [2];
  logic [7:0] rdata [2];

  int n_chk = 0;
  int n_fail = 0;

  // model state, per instance
  int         p_wl [2] = '{1, 3};
  int         p_gl [2] = '{0, 2};
  int         p_rl [2] = '{2, 2};
  slot_t      mq [2][$];
  logic       m_prev [2] = '{1'b1, 1'b1};
  logic       m_rv [2] = '{1'b0, 1'b0};
  logic       m_err [2] = '{1'b0, 1'b0};
  logic [7:0] m_rdata [2] = '{8'h00, 8'h00};
  logic [7:0] m_wdata [2] = '{8'h00, 8'h00};

  function automatic logic [7:0] mfun(input logic [7:0] a);
    return a ^ 8'h3C;
  endfunction

  assign mem_rdata[0] = mfun(addr[0]);
  assign mem_rdata[1] = mfun(addr[1]);

  always #5 clk = ~clk;

  rw_burst_sequencer #(.AW(8), .DW(8), .WR_LEN(1), .RD_LEN(2), .GAP(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .wr_data(wr_data),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata[0]), .wr(wr[0]), .rd(rd[0]),
    .addr(addr[0]), .wdata(wdata[0]), .rdata_valid(rvalid[0]), .rdata(rdata[0]),
    .busy(busy[0]), .done(done[0]), .err(err[0])
  );

  rw_burst_sequencer #(.AW(8), .DW(8), .WR_LEN(3), .RD_LEN(2), .GAP(2)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .wr_data(wr_data),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata[1]), .wr(wr[1]), .rd(rd[1]),
    .addr(addr[1]), .wdata(wdata[1]), .rdata_valid(rvalid[1]), .rdata(rdata[1]),
    .busy(busy[1]), .done(done[1]), .err(err[1])
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: each transaction is a queue of slots; beat slots leave only when accepted
  task automatic model_step();
    logic  rose;
    slot_t s;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        mq[i].delete();
        m_prev[i]  = 1'b1;
        m_rv[i]    = 1'b0;
        m_err[i]   = 1'b0;
        m_rdata[i] = 8'h00;
      end else begin
        rose      = start && !m_prev[i];
        m_prev[i] = start;
        m_rv[i]   = 1'b0;
        m_err[i]  = 1'b0;
        if (mq[i].size() != 0) begin
          if (rose) m_err[i] = 1'b1;
          s = mq[i][0];
          if (s.kind == K_I || s.kind == K_F) begin
            void'(mq[i].pop_front());
          end else if (mem_ready) begin
            if (s.kind == K_R) begin
              m_rv[i]    = 1'b1;
              m_rdata[i] = mfun(s.a);
            end
            void'(mq[i].pop_front());
          end
        end else if (rose) begin
          m_wdata[i] = wr_data;
          for (int j = 0; j < p_wl[i]; j++) mq[i].push_back('{K_W, base_addr + 8'(j)});
          for (int j = 0; j < p_gl[i]; j++) mq[i].push_back('{K_I, 8'h00});
          for (int j = 0; j < p_rl[i]; j++) mq[i].push_back('{K_R, base_addr + 8'(j)});
          mq[i].push_back('{K_F, 8'h00});
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Per-cycle comparison of both instances against the model
  initial forever begin
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      slot_t h;
      logic  has;
      int    e_wr, e_rd;
      has  = (mq[i].size() != 0);
      h    = has ? mq[i][0] : '{K_I, 8'h00};
      e_wr = (has && h.kind == K_W) ? 1 : 0;
      e_rd = (has && h.kind == K_R) ? 1 : 0;
      chk($sformatf("wr[%0d]", i), int'(wr[i]), e_wr);
      chk($sformatf("rd[%0d]", i), int'(rd[i]), e_rd);
      chk($sformatf("wr_rd_excl[%0d]", i), int'(wr[i] & rd[i]), 0);
      chk($sformatf("busy[%0d]", i), int'(busy[i]), has ? 1 : 0);
      chk($sformatf("done[%0d]", i), int'(done[i]), (has && h.kind == K_F) ? 1 : 0);
      chk($sformatf("err[%0d]", i), int'(err[i]), int'(m_err[i]));
      chk($sformatf("rvalid[%0d]", i), int'(rvalid[i]), int'(m_rv[i]));
      chk($sformatf("rdata[%0d]", i), int'(rdata[i]), int'(m_rdata[i]));
      if (e_wr == 1 || e_rd == 1) chk($sformatf("addr[%0d]", i), int'(addr[i]), int'(h.a));
      if (e_wr == 1) chk($sformatf("wdata[%0d]", i), int'(wdata[i]), int'(m_wdata[i]));
    end
  end

  task automatic wait_idle();
    int n = 0;
    start = 1'b0;
    while ((busy != 2'b00) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", (n < 100) ? 1 : 0, 1);
    repeat (2) @(negedge clk);
  endtask

  int g_wr [8] = '{1, 1, 1, 0, 0, 0, 0, 0};
  int g_rd [8] = '{0, 0, 0, 0, 0, 1, 1, 0};
  int g_ad [8] = '{'hFE, 'hFF, 'h00, 0, 0, 'hFE, 'hFF, 0};

  initial begin
    int nd;
    // reset state
    @(negedge clk);  // t=10
    for (int i = 0; i < 2; i++) begin
      chk("rst_wr", int'(wr[i]), 0);
      chk("rst_rd", int'(rd[i]), 0);
      chk("rst_busy", int'(busy[i]), 0);
      chk("rst_addr", int'(addr[i]), 0);
      chk("rst_wdata", int'(wdata[i]), 0);
      chk("rst_rdata", int'(rdata[i]), 0);
    end
    rst = 1'b0;
    base_addr = 8'h10;
    wr_data = 8'hA5;
    @(negedge clk);  // t=20
    start = 1'b1;

    // default timing on instance 0
    @(negedge clk);
    chk("t1_k1_wr", int'(wr[0]), 1);
    chk("t1_k1_addr", int'(addr[0]), 'h10);
    chk("t1_k1_wdata", int'(wdata[0]), 'hA5);
    start = 1'b0;
    @(negedge clk);
    chk("t1_k2_rd", int'(rd[0]), 1);
    chk("t1_k2_addr", int'(addr[0]), 'h10);
    @(negedge clk);
    chk("t1_k3_rd", int'(rd[0]), 1);
    chk("t1_k3_addr", int'(addr[0]), 'h11);
    chk("t1_k3_rv", int'(rvalid[0]), 1);
    chk("t1_k3_rdata", int'(rdata[0]), 'h2C);
    @(negedge clk);
    chk("t1_k4_rd", int'(rd[0]), 0);
    chk("t1_k4_rv", int'(rvalid[0]), 1);
    chk("t1_k4_rdata", int'(rdata[0]), 'h2D);
    chk("t1_k4_done", int'(done[0]), 1);
    @(negedge clk);
    chk("t1_k5_busy", int'(busy[0]), 0);
    chk("t1_k5_done", int'(done[0]), 0);
    wait_idle();

    // stall on the first read beat of instance 0
    start = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 5) begin
        chk("st_k5_rd", int'(rd[0]), 1);
        chk("st_k5_addr", int'(addr[0]), 'h10);
        chk("st_k5_rv", int'(rvalid[0]), 0);
      end
      if (k == 6) chk("st_k6_done", int'(done[0]), 0);
      if (k == 7) chk("st_k7_done", int'(done[0]), 1);
      if (k == 1) start = 1'b0;
      if (k == 2) mem_ready = 1'b0;
      if (k == 5) mem_ready = 1'b1;
    end
    wait_idle();

    // wrap and turnaround on instance 1
    base_addr = 8'hFE;
    wr_data = 8'h3C;
    start = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      start = 1'b0;
      chk($sformatf("gap_wr_k%0d", k), int'(wr[1]), g_wr[k]);
      chk($sformatf("gap_rd_k%0d", k), int'(rd[1]), g_rd[k]);
      if (g_wr[k] == 1 || g_rd[k] == 1) chk($sformatf("gap_addr_k%0d", k), int'(addr[1]), g_ad[k]);
      if (k == 3 || k == 4) chk($sformatf("gap_busy_k%0d", k), int'(busy[1]), 1);
    end
    chk("gap_done", int'(done[1]), 1);
    chk("gap_rdata", int'(rdata[1]), 'hC3);
    wait_idle();

    // start edge while busy
    base_addr = 8'h10;
    start = 1'b1;
    nd = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      nd += int'(done[0]);
      if (k == 3) chk("busy_err_k3", int'(err[0]), 1);
      if (k == 4) chk("busy_err_k4", int'(err[0]), 0);
      if (k == 1) start = 1'b0;
      if (k == 2) start = 1'b1;
      if (k == 3) start = 1'b0;
    end
    chk("busy_one_done", nd, 1);
    wait_idle();

    // reset during the read phase, start held high through reset
    start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_out", int'({wr, rd, busy, done, rvalid, err}), 0);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("mid_rst_noretrig", int'(busy[0]), 0);
    end
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    chk("mid_rst_fresh_wr", int'(wr[0]), 1);
    wait_idle();

    // back-to-back: start re-rises one cycle after done
    start = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 4) chk("b2b_done", int'(done[0]), 1);
      if (k == 6) begin
        chk("b2b_wr", int'(wr[0]), 1);
        chk("b2b_err", int'(err[0]), 0);
      end
      if (k == 1) start = 1'b0;
      if (k == 5) start = 1'b1;
    end
    wait_idle();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      mem_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 5) == 0) start = ~start;
      base_addr = 8'($urandom());
      wr_data = 8'($urandom());
      rst = ($urandom_range(0, 399) == 0);
    end
    rst = 1'b0;
    mem_ready = 1'b1;
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_chk, n_fail);
    $fatal(1);
  end

endmodule
